// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [2:0] {STG_NONE = 3'd0, STG_D = 3'd1, STG_E = 3'd2, STG_M = 3'd3} stage_e;
  typedef enum logic [2:0] {TNEW_PC8 = 3'd0, TNEW_IMM = 3'd1, TNEW_ALU = 3'd2, TNEW_MEM = 3'd3} tnew_e;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_E = 2'd1, FWD_M = 2'd2, FWD_W = 2'd3} fwd_e;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] cnt;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // Cycles spent in E before the result becomes forwardable.
  function automatic logic [1:0] init_cnt(input logic [2:0] tnew);
    if (tnew == TNEW_PC8)  return 2'd0;
    else if (tnew > 3'd3)  return 2'd3;
    else                   return tnew[1:0] - 2'd1;
  endfunction

  function automatic logic hit(input slot_t s, input logic [4:0] r);
    return (r != 5'd0) && (s.wa == r);
  endfunction

  function automatic logic conflict(input slot_t s, input logic [4:0] r, input logic [2:0] tuse);
    return (tuse != STG_NONE) && hit(s, r) && ({1'b0, s.cnt} >= tuse);
  endfunction

  // The youngest match shadows older ones, even when it is not ready yet.
  function automatic logic [1:0] pick(input slot_t se, input slot_t sm, input slot_t sw,
                                      input logic [4:0] r);
    if (hit(se, r))      return (se.cnt == 2'd0) ? FWD_E : FWD_RF;
    else if (hit(sm, r)) return (sm.cnt == 2'd0) ? FWD_M : FWD_RF;
    else if (hit(sw, r)) return (sw.cnt == 2'd0) ? FWD_W : FWD_RF;
    else                 return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One scoreboard slot: destination register plus cycles-until-forwardable.
module hazard_slot
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_bubble,
  input  logic  i_dec,
  input  slot_t i_slot,
  output slot_t o_slot
);

  slot_t r_slot;
  logic [1:0] w_cnt;

  assign w_cnt = (i_dec && i_slot.cnt != 2'd0) ? i_slot.cnt - 2'd1 : i_slot.cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_slot <= SLOT_EMPTY;
    else if (i_bubble) r_slot <= SLOT_EMPTY;
    else begin
      r_slot.wa  <= i_slot.wa;
      r_slot.cnt <= w_cnt;
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/hazard_unit.sv
// D-stage stall and forwarding-select generation from an E/M/W producer scoreboard.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [2:0]       d_tuse_rs,
  input  logic [2:0]       d_tuse_rt,
  input  logic             d_reg_write,
  input  logic [4:0]       d_wa,
  input  logic [2:0]       d_tnew,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic [1:0]       fwd_m_rt,
  output logic [CNT_W-1:0] stall_count
);

  slot_t            w_d_slot, w_e, w_m, w_w;
  logic             w_stall;
  logic [4:0]       r_e_rs, r_e_rt, r_m_rt;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_d_slot.wa  = d_reg_write ? d_wa : 5'd0;
  assign w_d_slot.cnt = init_cnt(d_tnew);

  hazard_slot u_slot_e (.clk(clk), .reset(reset), .i_bubble(w_stall), .i_dec(1'b0),
                        .i_slot(w_d_slot), .o_slot(w_e));
  hazard_slot u_slot_m (.clk(clk), .reset(reset), .i_bubble(1'b0), .i_dec(1'b1),
                        .i_slot(w_e), .o_slot(w_m));
  hazard_slot u_slot_w (.clk(clk), .reset(reset), .i_bubble(1'b0), .i_dec(1'b1),
                        .i_slot(w_m), .o_slot(w_w));

  assign w_stall = conflict(w_e, d_rs, d_tuse_rs) | conflict(w_m, d_rs, d_tuse_rs) |
                   conflict(w_w, d_rs, d_tuse_rs) | conflict(w_e, d_rt, d_tuse_rt) |
                   conflict(w_m, d_rt, d_tuse_rt) | conflict(w_w, d_rt, d_tuse_rt);

  // Consumers further down only see producers older than themselves.
  assign fwd_d_rs = pick(w_e, w_m, w_w, d_rs);
  assign fwd_d_rt = pick(w_e, w_m, w_w, d_rt);
  assign fwd_e_rs = pick(SLOT_EMPTY, w_m, w_w, r_e_rs);
  assign fwd_e_rt = pick(SLOT_EMPTY, w_m, w_w, r_e_rt);
  assign fwd_m_rt = pick(SLOT_EMPTY, SLOT_EMPTY, w_w, r_m_rt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e_rs      <= 5'd0;
      r_e_rt      <= 5'd0;
      r_m_rt      <= 5'd0;
      r_stall_cnt <= '0;
    end else begin
      r_e_rs <= w_stall ? 5'd0 : d_rs;
      r_e_rt <= w_stall ? 5'd0 : d_rt;
      r_m_rt <= r_e_rt;
      if (w_stall && r_stall_cnt != {CNT_W{1'b1}})
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall       = w_stall;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector table plus randomized run against an age-based pipeline model.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [2:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_reg_write;
  logic        stall;
  logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
  logic [31:0] stall_count;

  hazard_unit #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs),
    .d_tuse_rt(d_tuse_rt), .d_reg_write(d_reg_write), .d_wa(d_wa), .d_tnew(d_tnew),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
    .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs, rt, urs, urt, rw, wa, tn;
    int st, fdrs, fdrt, fers, fert, fmrt, cnt;
  } vec_t;

  typedef struct {
    int wa, tn, rs, rt;
  } mi_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];
  mi_t  mp[3];
  int   mcnt;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int rs, int rt, int urs, int urt, int rw, int wa, int tn,
                              int st, int fdrs, int fdrt, int fers, int fert, int fmrt, int cnt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rw = rw; v.wa = wa; v.tn = tn;
    v.st = st; v.fdrs = fdrs; v.fdrt = fdrt; v.fers = fers; v.fert = fert; v.fmrt = fmrt;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input int rs, input int rt, input int urs, input int urt,
                       input int rw, input int wa, input int tn);
    d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 3'(urs); d_tuse_rt = 3'(urt);
    d_reg_write = 1'(rw); d_wa = 5'(wa); d_tnew = 3'(tn);
  endtask

  task automatic chk_all(input string p, input int st, input int fdrs, input int fdrt,
                         input int fers, input int fert, input int fmrt, input int cnt);
    chk({p, ".stall"}, int'(stall), st);
    chk({p, ".fwd_d_rs"}, int'(fwd_d_rs), fdrs);
    chk({p, ".fwd_d_rt"}, int'(fwd_d_rt), fdrt);
    chk({p, ".fwd_e_rs"}, int'(fwd_e_rs), fers);
    chk({p, ".fwd_e_rt"}, int'(fwd_e_rt), fert);
    chk({p, ".fwd_m_rt"}, int'(fwd_m_rt), fmrt);
    chk({p, ".stall_count"}, int'(stall_count), cnt);
  endtask

  // Reference: entries carry Tnew and position; readiness is derived from age.
  function automatic int remn(int i);
    int r;
    r = mp[i].tn - 1 - i;
    return (r > 0) ? r : 0;
  endfunction

  function automatic int m_fwd(int r, int first);
    for (int i = first; i < 3; i++)
      if (r != 0 && mp[i].wa == r) return (remn(i) == 0) ? i + 1 : 0;
    return 0;
  endfunction

  function automatic int m_stall(int rs, int urs, int rt, int urt);
    for (int i = 0; i < 3; i++) begin
      if (mp[i].wa != 0 && urs != 0 && mp[i].wa == rs && remn(i) >= urs) return 1;
      if (mp[i].wa != 0 && urt != 0 && mp[i].wa == rt && remn(i) >= urt) return 1;
    end
    return 0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 3; i++) mp[i] = '{0, 0, 0, 0};
    mcnt = 0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // rs rt urs urt rw wa tn | stall fdrs fdrt fers fert fmrt cnt
    tbl.push_back(mk(29, 0, 2, 0, 1,  8, 3,  0, 0, 0, 0, 0, 0, 0)); // lw $8
    tbl.push_back(mk( 8, 0, 2, 0, 1, 11, 2,  1, 0, 0, 0, 0, 0, 0)); // load-use
    tbl.push_back(mk( 8, 0, 2, 0, 1, 11, 2,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk( 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 3, 0, 0, 1));
    tbl.push_back(mk( 1, 2, 2, 2, 1,  9, 2,  0, 0, 0, 0, 0, 0, 1)); // addu $9
    tbl.push_back(mk( 9, 0, 1, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 1)); // beq $9
    tbl.push_back(mk( 9, 0, 1, 0, 0,  0, 0,  0, 2, 0, 0, 0, 0, 2));
    tbl.push_back(mk( 0, 0, 0, 0, 1, 10, 3,  0, 0, 0, 3, 0, 0, 2)); // lw $10
    tbl.push_back(mk( 0,10, 1, 1, 0,  0, 0,  1, 0, 0, 0, 0, 0, 2)); // beq $10
    tbl.push_back(mk( 0,10, 1, 1, 0,  0, 0,  1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk( 0,10, 1, 1, 0,  0, 0,  0, 0, 3, 0, 0, 0, 4));
    tbl.push_back(mk( 0, 0, 0, 0, 1, 31, 0,  0, 0, 0, 0, 0, 0, 4)); // jal
    tbl.push_back(mk(31, 0, 1, 0, 0,  0, 0,  0, 1, 0, 0, 0, 0, 4)); // jr $31
    tbl.push_back(mk( 0, 0, 0, 0, 1,  0, 2,  0, 0, 0, 2, 0, 0, 4)); // write $0
    tbl.push_back(mk( 0, 0, 1, 1, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4)); // read $0
    tbl.push_back(mk( 0, 0, 0, 0, 1,  4, 1,  0, 0, 0, 0, 0, 0, 4)); // ori $4
    tbl.push_back(mk( 0, 0, 0, 0, 1,  4, 2,  0, 0, 0, 0, 0, 0, 4)); // addu $4
    tbl.push_back(mk( 0, 4, 2, 3, 0,  0, 0,  0, 0, 0, 0, 0, 0, 4)); // sw $4: E shadows M
    tbl.push_back(mk( 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 2, 0, 4));
    tbl.push_back(mk( 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 3, 4));
    tbl.push_back(mk( 0, 0, 0, 0, 1,  5, 1,  0, 0, 0, 0, 0, 0, 4)); // ori $5
    tbl.push_back(mk( 0, 5, 2, 3, 0,  0, 0,  0, 0, 1, 0, 0, 0, 4)); // sw $5
    tbl.push_back(mk( 0, 0, 0, 0, 1,  6, 3,  0, 0, 0, 0, 2, 0, 4)); // lw $6
    tbl.push_back(mk( 6, 6, 2, 2, 1, 12, 2,  1, 0, 0, 0, 0, 3, 4)); // rs&rt conflict
    tbl.push_back(mk( 6, 6, 2, 2, 1, 12, 2,  0, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk( 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 3, 3, 0, 5));
    tbl.push_back(mk( 0, 0, 0, 0, 1,  7, 1,  0, 0, 0, 0, 0, 0, 5)); // ori $7
    tbl.push_back(mk( 0, 0, 0, 0, 1,  7, 3,  0, 0, 0, 0, 0, 0, 5)); // lw $7
    tbl.push_back(mk( 7, 0, 2, 0, 1, 13, 2,  1, 0, 0, 0, 0, 0, 5)); // stalls on E
    tbl.push_back(mk( 7, 0, 2, 0, 1, 13, 2,  0, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk( 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 3, 0, 0, 6));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].rw, tbl[i].wa, tbl[i].tn);
      #1;
      chk_all($sformatf("v%0d", i), tbl[i].st, tbl[i].fdrs, tbl[i].fdrt, tbl[i].fers,
              tbl[i].fert, tbl[i].fmrt, tbl[i].cnt);
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 8, 3);
    @(negedge clk);
    drive(8, 8, 2, 2, 1, 14, 2);
    #1;
    chk("midrst.pre_stall", int'(stall), 1);
    chk("midrst.pre_count", int'(stall_count), 6);
    reset = 1'b1;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    m_clear();

    for (int c = 0; c < 3000; c++) begin
      int rs, rt, urs, urt, rw, wa, tn, es;
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        chk_all($sformatf("r%0d.reset", c), 0, 0, 0, 0, 0, 0, 0);
        m_clear();
        @(negedge clk);
        reset = 1'b0;
      end
      rs = $urandom_range(0, 3); rt = $urandom_range(0, 3);
      urs = $urandom_range(0, 3); urt = $urandom_range(0, 3);
      rw = $urandom_range(0, 1); wa = $urandom_range(0, 3); tn = $urandom_range(0, 3);
      drive(rs, rt, urs, urt, rw, wa, tn);
      #1;
      es = m_stall(rs, urs, rt, urt);
      chk_all($sformatf("r%0d", c), es, m_fwd(rs, 0), m_fwd(rt, 0), m_fwd(mp[0].rs, 1),
              m_fwd(mp[0].rt, 1), m_fwd(mp[1].rt, 2), mcnt);
      @(posedge clk);
      mp[2] = mp[1];
      mp[1] = mp[0];
      if (es != 0) mp[0] = '{0, 0, 0, 0};
      else         mp[0] = '{(rw != 0) ? wa : 0, tn, rs, rt};
      mcnt += es;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
